// File: rtl/mont_mult_serial.sv
// Bit-serial GF(p) arithmetic core.
// Computes the radix-2 Montgomery product a*b*2^-WIDTH mod p, and single-pass
// modular add and subtract. The modulus is taken from a port on each request.
module mont_mult_serial #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_p,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result
);

    // Two guard bits: acc + b + p stays below 4p < 2^(WIDTH+2).
    localparam int ACC_W = WIDTH + 2;
    localparam logic [CNT_W:0] CNT_LAST = (CNT_W + 1)'(WIDTH - 1);
    localparam logic [CNT_W:0] CNT_ONE  = (CNT_W + 1)'(1);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        ADDSUB,
        FIX,
        DONE
    } state_t;

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W:0]     cnt;
    logic [WIDTH-1:0]   a_reg;   // shifted right each iteration, a_reg[0] is the current bit
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   p_reg;
    logic [1:0]         op_reg;

    logic [ACC_W-1:0]   b_ext;
    logic [ACC_W-1:0]   p_ext;
    logic [ACC_W-1:0]   t_sum;
    logic [ACC_W-1:0]   t_odd;
    logic [ACC_W-1:0]   mul_next;
    logic [ACC_W-1:0]   add_val;
    logic [ACC_W-1:0]   sub_val;
    logic [WIDTH-1:0]   fix_val;

    // Datapath for one Montgomery iteration, add/sub and the final reduction.
    always_comb begin
        b_ext    = {2'b00, b_reg};
        p_ext    = {2'b00, p_reg};
        t_sum    = acc + (a_reg[0] ? b_ext : '0);
        // Adding p when odd makes the sum divisible by 2 without changing it mod p.
        t_odd    = t_sum[0] ? (t_sum + p_ext) : t_sum;
        mul_next = t_odd >> 1;
        add_val  = {2'b00, a_reg} + b_ext;
        // Bias by p so a - b never goes negative.
        sub_val  = {2'b00, a_reg} - b_ext + p_ext;
        fix_val  = (acc >= p_ext) ? WIDTH'(acc - p_ext) : acc[WIDTH-1:0];
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            p_reg    <= '0;
            op_reg   <= '0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        a_reg  <= i_a;
                        b_reg  <= i_b;
                        p_reg  <= i_p;
                        op_reg <= i_op;
                        acc    <= '0;
                        cnt    <= '0;
                        o_busy <= 1'b1;
                        state  <= (i_op == 2'b01 || i_op == 2'b10) ? ADDSUB : RUN;
                    end
                end
                RUN: begin
                    acc   <= mul_next;
                    a_reg <= a_reg >> 1;
                    cnt   <= cnt + CNT_ONE;
                    if (cnt == CNT_LAST) begin
                        state <= FIX;
                    end
                end
                ADDSUB: begin
                    acc   <= (op_reg == 2'b10) ? sub_val : add_val;
                    state <= FIX;
                end
                FIX: begin
                    o_result <= fix_val;
                    o_done   <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mont_mult_serial.sv
// Scoreboard bench for mont_mult_serial at WIDTH=8 and WIDTH=32.
module tb_mont_mult_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start8, start32;
    logic [1:0]  op8, op32;
    logic [7:0]  a8, b8, p8;
    logic [31:0] a32, b32, p32;
    logic        busy8, done8, busy32, done32;
    logic [7:0]  res8;
    logic [31:0] res32;

    int checks = 0;
    int passed = 0;
    logic [31:0] q8[$];
    logic [31:0] q32[$];

    mont_mult_serial #(.WIDTH(8)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_start(start8), .i_op(op8),
        .i_a(a8), .i_b(b8), .i_p(p8),
        .o_busy(busy8), .o_done(done8), .o_result(res8)
    );

    mont_mult_serial #(.WIDTH(32)) dut32 (
        .i_clk(clk), .i_rst(rst), .i_start(start32), .i_op(op32),
        .i_a(a32), .i_b(b32), .i_p(p32),
        .o_busy(busy32), .o_done(done32), .o_result(res32)
    );

    // Reference: plain modular arithmetic; 2^-w mod p is ((p+1)/2)^w mod p.
    function automatic longint unsigned ref_model(input int op, input longint unsigned a,
                                                  input longint unsigned b,
                                                  input longint unsigned p, input int w);
        longint unsigned half, rinv;
        if (op == 1) return (a + b) % p;
        if (op == 2) return (a + p - b) % p;
        half = (p + 1) / 2;
        rinv = 1;
        for (int i = 0; i < w; i++) rinv = (rinv * half) % p;
        return (((a * b) % p) * rinv) % p;
    endfunction

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: every done pulse pops the oldest expected result.
    always @(posedge clk) begin
        #1;
        if (done8) begin
            if (q8.size() == 0) check("unexpected_done8", 1, 0);
            else check("result8", res8, q8.pop_front());
            $display("w8  done result=%0d", res8);
        end
        if (done32) begin
            if (q32.size() == 0) check("unexpected_done32", 1, 0);
            else check("result32", res32, q32.pop_front());
            $display("w32 done result=%0h", res32);
        end
    end

    // Issue one op, return the edge count (accepting edge = 1) at which done appeared.
    task automatic do_op(input bit sel, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] p, output int lat);
        @(negedge clk);
        if (sel) begin
            op32 = op; a32 = a; b32 = b; p32 = p; start32 = 1'b1;
            q32.push_back(32'(ref_model(int'(op), a, b, p, 32)));
        end else begin
            op8 = op; a8 = a[7:0]; b8 = b[7:0]; p8 = p[7:0]; start8 = 1'b1;
            q8.push_back(32'(ref_model(int'(op), a, b, p, 8)));
        end
        @(posedge clk);
        #1;
        start8 = 1'b0;
        start32 = 1'b0;
        check("busy_after_accept", sel ? busy32 : busy8, 1);
        lat = 1;
        while (!(sel ? done32 : done8) && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (lat >= 200) check("done_timeout", 0, 1);
        check("busy_in_done", sel ? busy32 : busy8, 1);
        @(posedge clk);
        #1;
        check("busy_after_done", sel ? busy32 : busy8, 0);
        check("done_one_cycle", sel ? done32 : done8, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, cyc, edges, ndone;
        int t[3];
        logic [31:0] ra, rb;
        localparam logic [31:0] P32 = 32'hFFFF_FFFB;

        rst = 1'b1;
        start8 = 0; start32 = 0; op8 = 0; op32 = 0;
        a8 = 0; b8 = 0; p8 = 0; a32 = 0; b32 = 0; p32 = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy32", busy32, 0);
        check("reset_done32", done32, 0);
        check("reset_result32", res32, 0);
        check("reset_busy8", busy8, 0);
        check("reset_result8", res8, 0);
        @(negedge clk);
        rst = 1'b0;

        // WIDTH=8 directed vectors
        do_op(0, 2'b00, 1, 5, 251, lat);
        check("mul8_latency", lat, 10);
        check("mul8_1x5", res8, 1);
        do_op(0, 2'b00, 250, 250, 251, lat);
        check("mul8_250x250", res8, 201);
        do_op(0, 2'b00, 0, 137, 251, lat);
        check("mul8_0x137", res8, 0);
        do_op(0, 2'b11, 250, 250, 251, lat);
        check("op11_as_mul", res8, 201);
        do_op(0, 2'b01, 200, 100, 251, lat);
        check("add8_latency", lat, 3);
        check("add8", res8, 49);
        do_op(0, 2'b10, 10, 20, 251, lat);
        check("sub8_latency", lat, 3);
        check("sub8_wrap", res8, 241);
        do_op(0, 2'b10, 20, 10, 251, lat);
        check("sub8", res8, 10);

        // WIDTH=32 directed and random
        do_op(1, 2'b00, 1, 5, P32, lat);
        check("mul32_latency", lat, 34);
        check("mul32_1x5", res32, 1);
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom % P32;
            rb = $urandom % P32;
            do_op(1, 2'b00, ra, rb, P32, lat);
        end
        for (int i = 0; i < 200; i++) begin
            ra = $urandom % P32;
            rb = $urandom % P32;
            do_op(1, 2'($urandom_range(1, 2)), ra, rb, P32, lat);
        end

        // Input changes and start pulses during a multiply are ignored
        @(negedge clk);
        ra = $urandom % P32; rb = $urandom % P32;
        op32 = 2'b00; a32 = ra; b32 = rb; p32 = P32; start32 = 1'b1;
        q32.push_back(32'(ref_model(0, ra, rb, P32, 32)));
        @(posedge clk);
        #1;
        start32 = 1'b0;
        cyc = 1;
        while (!done32 && cyc < 200) begin
            @(negedge clk);
            start32 = (cyc == 5 || cyc == 20);
            if (cyc == 5 || cyc == 20) a32 = $urandom;
            @(posedge clk);
            #1;
            cyc++;
        end
        start32 = 1'b0;
        check("mid_op_latency", cyc, 34);
        repeat (40) @(posedge clk);

        // Start held high: ops repeat with one IDLE cycle between them
        for (int i = 0; i < 3; i++) q8.push_back(32'(ref_model(0, 250, 137, 251, 8)));
        @(negedge clk);
        op8 = 2'b00; a8 = 250; b8 = 137; p8 = 251; start8 = 1'b1;
        edges = 0; ndone = 0;
        while (ndone < 3 && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
            if (done8) begin
                t[ndone] = edges;
                ndone++;
                if (ndone == 3) start8 = 1'b0;
            end
        end
        start8 = 1'b0;
        check("held_start_count", ndone, 3);
        check("held_first_done", t[0], 10);
        check("held_gap1", t[1] - t[0], 11);
        check("held_gap2", t[2] - t[1], 11);
        repeat (20) @(posedge clk);

        // Asynchronous reset aborts a multiply at cycle 12
        @(negedge clk);
        op32 = 2'b00; a32 = 12345; b32 = 67890; p32 = P32; start32 = 1'b1;
        @(posedge clk);
        #1;
        start32 = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", busy32, 0);
        check("abort_done", done32, 0);
        check("abort_result", res32, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        do_op(1, 2'b00, 1, 5, P32, lat);
        check("post_reset_latency", lat, 34);
        check("post_reset_result", res32, 1);

        repeat (5) @(posedge clk);
        check("q8_drained", q8.size(), 0);
        check("q32_drained", q32.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
